// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM port bundle used for both requester ports and the SDRAM master port.
// Ports: read/write/address/writedata/byteenable (command), waitrequest,
//        readdata/readdatavalid (response). master drives commands, slave answers.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32
);
  logic                  read;
  logic                  write;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     writedata;
  logic [DATA_W/8-1:0]   byteenable;
  logic                  waitrequest;
  logic [DATA_W-1:0]     readdata;
  logic                  readdatavalid;

  modport master (
    output read, write, address, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  read, write, address, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM Avalon-MM master between port A (video reads, fixed high
// priority) and port B (draw engine read/write); read returns are steered back
// to their issuer through an owner-tag FIFO.
// Latency: zero-cycle command path, zero-cycle readdatavalid steer.
// Backpressure: avm waitrequest freezes the grant and re-presents the latched
// command; the ungranted port always sees waitrequest=1.
// Ports: clk, reset (sync, active-high); a (slave, read-only use), b (slave),
//        avm (master toward the SDRAM controller).
// Option: define SDRAM_ARB_STARVE_GUARD_EN to force a B grant after
//         STARVE_LIMIT consecutive A grants while B is waiting.
module sdram_port_arbiter #(
  parameter int ADDR_W       = 25,
  parameter int DATA_W       = 32,
  parameter int MAX_PEND     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  sdram_port_arbiter_if.slave   a,
  sdram_port_arbiter_if.slave   b,
  sdram_port_arbiter_if.master  avm
);

  localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CNT_W = $clog2(MAX_PEND + 1);
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, HOLD_A, HOLD_B} state_t;

  state_t state, next_state;

  // owner-tag FIFO: 0 = port A, 1 = port B
  logic             tag_mem [MAX_PEND];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty;

  // command latched on entry to a hold state, so a requester that drops its
  // request mid-hold cannot change what the SDRAM sees
  logic              hold_read, hold_write;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;
  logic [BE_W-1:0]   hold_be;

  logic              gnt_a, gnt_b;
  logic              cmd_read, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [BE_W-1:0]   cmd_be;

  logic a_elig, b_elig, force_b;
  logic accept, push, pop;

  assign full   = (count == CNT_W'(MAX_PEND));
  assign empty  = (count == '0);
  // reads need a free tag slot; writes never return data so they bypass it
  assign a_elig = a.read & ~full;
  assign b_elig = b.write | (b.read & ~full);

`ifdef SDRAM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign force_b = (starve_cnt >= 4'(STARVE_LIMIT)) & b_elig;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!(b.read | b.write)) begin
      starve_cnt <= '0;
    end else if (accept && gnt_b) begin
      starve_cnt <= '0;
    end else if (accept && gnt_a && starve_cnt != 4'hF) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign force_b = 1'b0;
`endif

  always_comb begin
    next_state = state;
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    cmd_read   = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    cmd_be     = '0;

    case (state)
      IDLE: begin
        if (a_elig && !force_b) begin
          gnt_a    = 1'b1;
          cmd_read = 1'b1;
          cmd_addr = a.address;
        end else if (b_elig) begin
          gnt_b     = 1'b1;
          cmd_write = b.write;
          cmd_read  = b.read & ~b.write;
          cmd_addr  = b.address;
          cmd_wdata = b.writedata;
          cmd_be    = b.byteenable;
        end
        if ((gnt_a || gnt_b) && avm.waitrequest) begin
          next_state = gnt_a ? HOLD_A : HOLD_B;
        end
      end
      HOLD_A, HOLD_B: begin
        gnt_a     = (state == HOLD_A);
        gnt_b     = (state == HOLD_B);
        cmd_read  = hold_read;
        cmd_write = hold_write;
        cmd_addr  = hold_addr;
        cmd_wdata = hold_wdata;
        cmd_be    = hold_be;
        if (!avm.waitrequest) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase

    // reset masks everything visible so nothing is accepted or pushed
    if (reset) begin
      gnt_a     = 1'b0;
      gnt_b     = 1'b0;
      cmd_read  = 1'b0;
      cmd_write = 1'b0;
    end
  end

  assign accept = (cmd_read | cmd_write) & ~avm.waitrequest;
  assign push   = accept & cmd_read;
  assign pop    = avm.readdatavalid & ~empty & ~reset;

  assign avm.read       = cmd_read;
  assign avm.write      = cmd_write;
  assign avm.address    = cmd_addr;
  assign avm.writedata  = cmd_wdata;
  assign avm.byteenable = cmd_be;

  assign a.waitrequest   = gnt_a ? avm.waitrequest : 1'b1;
  assign b.waitrequest   = gnt_b ? avm.waitrequest : 1'b1;
  assign a.readdata      = avm.readdata;
  assign b.readdata      = avm.readdata;
  assign a.readdatavalid = pop & ~tag_mem[rd_ptr];
  assign b.readdatavalid = pop &  tag_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= next_state;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   if (!full)  count <= count + CNT_W'(1);
        2'b01:   if (!empty) count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= gnt_b;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      hold_read  <= cmd_read;
      hold_write <= cmd_write;
      hold_addr  <= cmd_addr;
      hold_wdata <= cmd_wdata;
      hold_be    <= cmd_be;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;
  localparam int AW    = 25;
  localparam int DW    = 32;
  localparam int MAXP  = 4;
  localparam int LIMIT = 8;

  logic clk;
  logic reset;

  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a_if ();
  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b_if ();
  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m_if ();

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PEND(MAXP), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a_if),
    .b     (b_if),
    .avm   (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [3:0]    be;
    logic          port;
  } cmd_t;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rsp_t;

  // reference model: owners of outstanding reads in issue order, the command
  // currently stalled by waitrequest, and the SDRAM's pending return words
  bit    owner_q[$];
  rsp_t  rq[$];
  bit    held_vld;
  cmd_t  held;
  int    streak;
  int    cyc;
  int    lat;
  int    nvec;
  int    nerr;
  int    b_grants;

  function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] ad);
    return (32'(ad) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit ar, input logic [AW-1:0] aa,
                      input bit br, input bit bw, input logic [AW-1:0] ba,
                      input logic [DW-1:0] bwd, input logic [3:0] bbe,
                      input bit w, input bit stray);
    bit            rdv;
    logic [DW-1:0] rdat;
    int            gnt;
    cmd_t          c;
    bit            room, a_ok, b_ok, frc;
    bit            exp_ardv, exp_brdv;
    rsp_t          r;

    rdv  = 1'b0;
    rdat = $urandom;
    if (!rst && rq.size() > 0 && rq[0].due == cyc) begin
      rdv  = 1'b1;
      rdat = rq[0].d;
      rq.delete(0);
    end else if (!rst && stray) begin
      rdv = 1'b1;
    end

    reset              = rst;
    a_if.read          = ar;
    a_if.write         = 1'b0;
    a_if.address       = aa;
    a_if.writedata     = '0;
    a_if.byteenable    = '0;
    b_if.read          = br;
    b_if.write         = bw;
    b_if.address       = ba;
    b_if.writedata     = bwd;
    b_if.byteenable    = bbe;
    m_if.waitrequest   = w;
    m_if.readdatavalid = rdv;
    m_if.readdata      = rdat;

    gnt = 0;
    c   = '0;
    frc = 1'b0;
    if (!rst) begin
      if (held_vld) begin
        c   = held;
        gnt = held.port ? 2 : 1;
      end else begin
        room = owner_q.size() < MAXP;
        a_ok = ar && room;
        b_ok = bw || (br && room);
`ifdef SDRAM_ARB_STARVE_GUARD_EN
        frc = (streak >= LIMIT) && b_ok;
`endif
        if (a_ok && !frc) begin
          gnt = 1; c.rd = 1'b1; c.addr = aa; c.port = 1'b0;
        end else if (b_ok) begin
          gnt = 2; c.wr = bw; c.rd = !bw; c.addr = ba; c.wd = bwd; c.be = bbe; c.port = 1'b1;
        end
      end
    end
    exp_ardv = !rst && rdv && owner_q.size() > 0 && owner_q[0] == 1'b0;
    exp_brdv = !rst && rdv && owner_q.size() > 0 && owner_q[0] == 1'b1;

    #1;
    chk("avm_read",  32'(m_if.read),  32'(c.rd));
    chk("avm_write", 32'(m_if.write), 32'(c.wr));
    if (c.rd || c.wr) chk("avm_address", 32'(m_if.address), 32'(c.addr));
    if (c.wr) begin
      chk("avm_writedata",  m_if.writedata,        c.wd);
      chk("avm_byteenable", 32'(m_if.byteenable), 32'(c.be));
    end
    chk("a_waitrequest",   32'(a_if.waitrequest),   (gnt == 1) ? 32'(w) : 32'd1);
    chk("b_waitrequest",   32'(b_if.waitrequest),   (gnt == 2) ? 32'(w) : 32'd1);
    chk("a_readdatavalid", 32'(a_if.readdatavalid), 32'(exp_ardv));
    chk("b_readdatavalid", 32'(b_if.readdatavalid), 32'(exp_brdv));
    chk("a_readdata", a_if.readdata, rdat);
    chk("b_readdata", b_if.readdata, rdat);

    @(posedge clk);
    if (rst) begin
      owner_q.delete();
      rq.delete();
      held_vld = 1'b0;
      streak   = 0;
    end else begin
      if (rdv && owner_q.size() > 0) owner_q.delete(0);
      if (gnt != 0) begin
        if (!w) begin
          held_vld = 1'b0;
          if (gnt == 2) b_grants++;
          if (c.rd) begin
            owner_q.push_back(c.port);
            r.due = cyc + lat;
            r.d   = mkdata(c.addr);
            rq.push_back(r);
          end
        end else begin
          held_vld = 1'b1;
          held     = c;
        end
      end
      if (!(br || bw))               streak = 0;
      else if (gnt == 2 && !w)       streak = 0;
      else if (gnt == 1 && !w && streak < 15) streak++;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, '0, '0, 0, 0);
  endtask

  initial begin
    nvec = 0; nerr = 0; cyc = 0; lat = 3; streak = 0; held_vld = 0; b_grants = 0;
    @(posedge clk); #1;

    // reset state
    for (int i = 0; i < 2; i++) step(1, 1, 25'h1, 1, 0, 25'h2, '0, '0, 0, 0);
    idle(1);

    // solo A reads, 3-cycle latency
    for (int i = 0; i < 4; i++) step(0, 1, 25'h100 + 25'(i), 0, 0, '0, '0, '0, 0, 0);
    idle(6);

    // simultaneous A read and B write
    for (int i = 0; i < 2; i++) step(0, 1, 25'h180, 0, 1, 25'h200, 32'hDEADBEEF, 4'hF, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, '0, 0, 1, 25'h200, 32'hDEADBEEF, 4'hF, 0, 0);
    idle(5);

    // hold a B read under 5 cycles of waitrequest; A arrives mid-hold
    for (int i = 0; i < 5; i++) step(0, i >= 2, 25'h190, 1, 0, 25'h240, '0, '0, 1, 0);
    step(0, 1, 25'h190, 1, 0, 25'h240, '0, '0, 0, 0);
    step(0, 1, 25'h190, 0, 0, '0, '0, '0, 0, 0);
    idle(5);

    // interleaved returns, then a full FIFO: A waits, B write goes through
    lat = 8;
    step(0, 1, 25'h300, 0, 0, '0, '0, '0, 0, 0);
    step(0, 0, '0, 1, 0, 25'h400, '0, '0, 0, 0);
    step(0, 1, 25'h301, 0, 0, '0, '0, '0, 0, 0);
    step(0, 0, '0, 1, 0, 25'h401, '0, '0, 0, 0);
    step(0, 1, 25'h302, 0, 1, 25'h500, 32'h1234_5678, 4'h3, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 25'h302, 0, 0, '0, '0, '0, 0, 0);
    idle(12);

    // stray readdatavalid with nothing outstanding
    step(0, 0, '0, 0, 0, '0, '0, '0, 0, 1);
    step(0, 0, '0, 0, 0, '0, '0, '0, 0, 1);

    // reset with two reads pending and a held command
    step(0, 1, 25'h600, 0, 0, '0, '0, '0, 0, 0);
    step(0, 0, '0, 1, 0, 25'h601, '0, '0, 0, 0);
    step(0, 1, 25'h602, 0, 0, '0, '0, '0, 1, 0);
    step(1, 1, 25'h602, 1, 0, 25'h603, '0, '0, 0, 0);
    lat = 3;
    step(0, 1, 25'h610, 0, 0, '0, '0, '0, 0, 0);
    idle(6);

    // A and B both reading continuously
    b_grants = 0;
    for (int i = 0; i < 40; i++) step(0, 1, 25'h700 + 25'(i), 1, 0, 25'h800 + 25'(i), '0, '0, 0, 0);
`ifndef SDRAM_ARB_STARVE_GUARD_EN
    chk("starve_b_grants", 32'(b_grants), 32'd0);
`endif
    idle(6);

    // randomized traffic
    lat = 5;
    for (int i = 0; i < 400; i++) begin
      bit bw_r, br_r;
      bw_r = ($urandom % 3) == 0;
      br_r = !bw_r && ($urandom % 2) == 0;
      step(($urandom % 97) == 0, ($urandom % 3) != 0, 25'($urandom),
           br_r, bw_r, 25'($urandom), $urandom, 4'($urandom),
           ($urandom % 4) == 0, ($urandom % 16) == 0);
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-requester arbiter that shares the SoC's single 32-bit SDRAM Avalon-MM slave between the video frame reader (port A, read-only) and the sprite/draw engine (port B, read/write). A is served at fixed high priority so scan-out never underruns. B gets all remaining slots. Pipelined reads are tracked by an owner-tag FIFO so that each returned word is routed to the requester that issued it. The block sits in the top level between the two fabric engines and the SDRAM master port of `boxhead_soc`.

## Interface
- `ADDR_W`, 25: word address width (13 row + 2 bank + 10 col).
- `DATA_W`, 32: data width; byteenable is `DATA_W/8`.
- `MAX_PEND`, 4: maximum reads outstanding on the master (tag FIFO depth, power of 2).
- `STARVE_LIMIT`, 8: consecutive A grants before B is forced (only when macro enabled).
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `a_read`, `a_address[ADDR_W]`  in  port A request.
- `a_waitrequest`  out  1; `a_readdata[DATA_W]`  out; `a_readdatavalid`  out  1.
- `b_read`, `b_write`  in  1 each; `b_address[ADDR_W]`, `b_writedata[DATA_W]`, `b_byteenable[DATA_W/8]`  in.
- `b_waitrequest`  out  1; `b_readdata[DATA_W]`  out; `b_readdatavalid`  out  1.
- `avm_read`, `avm_write`  out  1; `avm_address`, `avm_writedata`, `avm_byteenable`  out; `avm_waitrequest`  in  1.
- `avm_readdata[DATA_W]`  in; `avm_readdatavalid`  in  1.

## Operation
- States: `IDLE`, `HOLD_A`, `HOLD_B`.
- In `IDLE`, the grant decision is combinational each cycle. Port A is granted if `a_read`. Otherwise port B is granted if `b_read|b_write`.
- A read request is ineligible while the tag FIFO is full. A write from B is eligible even when the FIFO is full.
- The granted port's command drives `avm_*` in the same cycle. The granted `x_waitrequest` equals `avm_waitrequest`. The ungranted port sees waitrequest = 1.
- If `avm_waitrequest`=1 for the granted command, go to `HOLD_A`/`HOLD_B`. While holding, the grant is frozen and the command is re-presented unchanged until accepted. Acceptance means the command is asserted with `avm_waitrequest`=0. On acceptance, return to `IDLE`.
- On acceptance of a read, push the owner tag (0=A, 1=B) into the tag FIFO.
- On `avm_readdatavalid`, pop the head tag and assert the matching `x_readdatavalid` for exactly that cycle.
- `a_readdata` and `b_readdata` both mirror `avm_readdata` at all times. Only the valid signals are steered.
- Push and pop in the same cycle: the occupancy count is unchanged and both operations are applied.
- Pop with the FIFO empty (a protocol error) is dropped: neither valid asserts and the count stays 0.
- Count arithmetic is modulo-free: the count saturates at 0 and at `MAX_PEND`. Pointers are `log2(MAX_PEND)` bits and wrap.
- A requester that drops its request while in `HOLD_*` violates Avalon. The block still holds until acceptance or reset.

## Timing
- Zero-cycle request path: a request in cycle n appears on `avm_*` in cycle n if granted.
- Read return: `x_readdatavalid` asserts in the same cycle as `avm_readdatavalid`, which is a combinational steer from the FIFO head.
- Back-to-back A reads with `avm_waitrequest`=0 issue one per cycle, up to `MAX_PEND` outstanding.
- Reset values (while `reset`=1 and the cycle after): state = `IDLE`, FIFO empty.
- During reset, outputs are forced: `avm_read`=`avm_write`=0, `a_waitrequest`=`b_waitrequest`=1, both readdatavalid = 0.
- Reset mid-operation discards held commands and pending tags. The SDRAM controller shares this reset, so no stale data returns.

## Configuration
- Macro `SDRAM_ARB_STARVE_GUARD_EN`.
- Defined:
  - A 4-bit counter increments on each accepted A command while B is requesting.
  - It clears on any accepted B command, or when B is not requesting.
  - When the count reaches `STARVE_LIMIT`, the next `IDLE` decision grants B even if `a_read`=1, then the counter clears.
- Undefined: strict fixed priority. B can starve indefinitely, and the counter logic is absent.

## Test plan
- **Solo A reads.** A reads 0x0000100..0x0000103 back-to-back with `avm_waitrequest`=0 and data returned with 3-cycle latency. Expect 4 commands in 4 cycles and 4 `a_readdatavalid` pulses in order. `b_readdatavalid` stays 0 throughout.
- **Simultaneous A and B requests.**
  - Stimulus: `a_read`=1 and `b_write`=1 (addr 0x0000200, data 0xDEADBEEF, be 0xF) in the same cycle.
  - A is granted first and B sees waitrequest = 1. The B write issues in the next `IDLE` cycle after A drops its request.
- **Hold under waitrequest.** Hold `avm_waitrequest`=1 for 5 cycles during a B read. Expect the B command stable for 6 cycles. A read asserted mid-hold is not granted until after acceptance.
- **Interleaved read returns.** Issue reads A, B, A, B with returns in order. Expect the valids routed A, B, A, B. With the FIFO full (4 pending), a new A read waits, while a B write is issued.
- **Starve guard** (macro defined, `STARVE_LIMIT`=8). Keep A and B reading continuously. Expect 8 A grants, then 1 B grant, repeating. With the macro undefined, expect zero B grants.
- **Reset mid-operation.** Assert `reset` with 2 reads pending. Expect the FIFO to clear, waitrequests = 1, and `avm_read`=0. Afterward, the first A read issues normally.
